// File: rtl/alarm_pkg.sv
// Shared types and time-of-day constants for the alarm scheduler slice.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam logic [7:0] HOURS_PER_DAY = 8'd24;
  localparam logic [7:0] MINS_PER_HOUR = 8'd60;

endpackage

// File: rtl/time_add_mins.sv
// Combinational hh:mm + n minutes with minute carry and midnight wrap.
// add_mins is expected below one hour, so at most one carry can occur.
module time_add_mins
  import alarm_pkg::*;
(
  input  logic [7:0] hours,
  input  logic [7:0] mins,
  input  logic [7:0] add_mins,
  output logic [7:0] sum_hours,
  output logic [7:0] sum_mins
);

  logic [8:0] raw_mins;
  logic       carry;

  always_comb begin
    raw_mins  = {1'b0, mins} + {1'b0, add_mins};
    carry     = (raw_mins >= {1'b0, MINS_PER_HOUR});
    sum_mins  = carry ? 8'(raw_mins - {1'b0, MINS_PER_HOUR}) : raw_mins[7:0];
    sum_hours = hours + {7'd0, carry};
    if (sum_hours >= HOURS_PER_DAY) begin
      sum_hours = sum_hours - HOURS_PER_DAY;
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm clock scheduler: slot storage, match detection and a
// ring/snooze state machine that services the lowest-index pending slot.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sec_tick,
  input  logic                          min_tick,
  input  logic [7:0]                    real_hours,
  input  logic [7:0]                    real_mins,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_ALARMS)-1:0] cfg_idx,
  input  logic [7:0]                    cfg_hours,
  input  logic [7:0]                    cfg_mins,
  input  logic                          cfg_en,
  input  logic                          btn_snooze,
  input  logic                          btn_dismiss,
  output logic                          ring,
  output logic [$clog2(NUM_ALARMS)-1:0] ring_idx,
  output logic [NUM_ALARMS-1:0]         pending,
  output logic                          snooze_active,
  output logic                          cfg_err
);

  localparam int IDX_W = $clog2(NUM_ALARMS);
  localparam int CNT_W = $clog2(RING_SECS + 1);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);

  alarm_state_t state, state_next;

  logic             slot_en    [NUM_ALARMS];
  logic [7:0]       slot_hours [NUM_ALARMS];
  logic [7:0]       slot_mins  [NUM_ALARMS];

  logic [CNT_W-1:0] ring_cnt;
  logic [7:0]       snz_hours, snz_mins;
  logic [7:0]       tgt_hours, tgt_mins;

  logic                  cfg_valid;
  logic                  disable_cur;
  logic                  snooze_hit;
  logic                  any_pending;
  logic [NUM_ALARMS-1:0] match;
  logic [NUM_ALARMS-1:0] write_hit;
  logic [NUM_ALARMS-1:0] grant_clr;
  logic [IDX_W-1:0]      grant_idx;
  logic                  take_grant;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  tgt_load;

  time_add_mins u_snooze_add (
    .hours     (real_hours),
    .mins      (real_mins),
    .add_mins  (8'(SNOOZE_MINS)),
    .sum_hours (tgt_hours),
    .sum_mins  (tgt_mins)
  );

  // Matches use the stored slot contents, so a same-cycle write never affects them.
  always_comb begin
    cfg_valid   = cfg_we && (cfg_hours < HOURS_PER_DAY) && (cfg_mins < MINS_PER_HOUR)
                  && (int'(cfg_idx) < NUM_ALARMS);
    disable_cur = cfg_valid && !cfg_en && (cfg_idx == ring_idx);
    snooze_hit  = min_tick && (real_hours == snz_hours) && (real_mins == snz_mins);
    any_pending = |pending;
    match       = '0;
    write_hit   = '0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i]     = min_tick && slot_en[i] && (slot_hours[i] == real_hours)
                     && (slot_mins[i] == real_mins);
      write_hit[i] = cfg_valid && (int'(cfg_idx) == i);
    end
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending[i]) grant_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Dismiss (or disabling the active slot) outranks everything; new pending
  // work outranks a snooze expiry.
  always_comb begin
    state_next    = state;
    take_grant    = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    tgt_load      = 1'b0;
    ring          = (state == RINGING);
    snooze_active = (state == SNOOZE);
    case (state)
      IDLE: begin
        if (any_pending) begin
          state_next = RINGING;
          take_grant = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      RINGING: begin
        if (btn_dismiss || disable_cur) begin
          state_next = IDLE;
        end else if (btn_snooze) begin
          state_next = SNOOZE;
          tgt_load   = 1'b1;
        end else if (sec_tick) begin
          if (ring_cnt == RING_LAST) state_next = IDLE;
          else                       cnt_inc    = 1'b1;
        end
      end
      SNOOZE: begin
        if (btn_dismiss || disable_cur) begin
          state_next = IDLE;
        end else if (any_pending) begin
          state_next = RINGING;
          take_grant = 1'b1;
          cnt_clr    = 1'b1;
        end else if (snooze_hit) begin
          state_next = RINGING;
          cnt_clr    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_clr = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      grant_clr[i] = take_grant && (int'(grant_idx) == i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_en[i]    <= 1'b0;
        slot_hours[i] <= 8'd0;
        slot_mins[i]  <= 8'd0;
      end
    end else if (cfg_valid) begin
      slot_en[cfg_idx]    <= cfg_en;
      slot_hours[cfg_idx] <= cfg_hours;
      slot_mins[cfg_idx]  <= cfg_mins;
    end
  end

  // A write to a slot cancels any match it had waiting, even one raised this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      ring_idx  <= '0;
      ring_cnt  <= '0;
      snz_hours <= 8'd0;
      snz_mins  <= 8'd0;
      cfg_err   <= 1'b0;
    end else begin
      pending <= (pending | match) & ~grant_clr & ~write_hit;
      cfg_err <= cfg_we && !cfg_valid;
      if (take_grant) ring_idx <= grant_idx;
      if (cnt_clr)      ring_cnt <= '0;
      else if (cnt_inc) ring_cnt <= ring_cnt + 1'b1;
      if (tgt_load) begin
        snz_hours <= tgt_hours;
        snz_mins  <= tgt_mins;
      end
    end
  end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4, number of alarm slots (2..8).
REQ-002 SHALL have parameter RING_SECS, default 60, ring duration before auto-dismiss, in sec_tick pulses.
REQ-003 SHALL have parameter SNOOZE_MINS, default 9, snooze interval in minutes (1..59).
REQ-004 clk  input  1  system clock; all state on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 sec_tick  input  1  one-cycle pulse once per second.
REQ-007 min_tick  input  1  one-cycle pulse on the cycle real_hours/real_mins take a new value.
REQ-008 real_hours  input  8  current hour, binary 0..23.
REQ-009 real_mins  input  8  current minute, binary 0..59.
REQ-010 cfg_we  input  1  one-cycle slot write strobe.
REQ-011 cfg_idx  input  $clog2(NUM_ALARMS)  slot being written.
REQ-012 cfg_hours, cfg_mins  input  8 each  alarm time to store.
REQ-013 cfg_en  input  1  enable bit to store.
REQ-014 btn_snooze, btn_dismiss  input  1 each  debounced one-cycle pulses.
REQ-015 ring  output  1  drives the sound module's trigger.
REQ-016 ring_idx  output  $clog2(NUM_ALARMS)  slot currently ringing or snoozed.
REQ-017 pending  output  NUM_ALARMS  matched alarms awaiting service.
REQ-018 snooze_active  output  1  high in SNOOZE.
REQ-019 cfg_err  output  1  one-cycle pulse on rejected write.

Function
REQ-020 Write with cfg_hours>23, cfg_mins>59 or cfg_idx>=NUM_ALARMS SHALL be ignored and pulse cfg_err the next cycle.
REQ-021 On a min_tick cycle, every enabled slot whose stored time equals real_hours/real_mins SHALL set its pending bit at the next edge; slot state is compared before a same-cycle write.
REQ-022 States SHALL be IDLE, RINGING, SNOOZE.
REQ-023 IDLE: pending nonzero -> RINGING, granting lowest-index pending slot, clearing its bit, loading ring_idx; ring high one cycle after pending is set (min_tick at t -> ring at t+2).
REQ-024 RINGING: ring=1; btn_dismiss -> IDLE; btn_snooze -> SNOOZE; RING_SECS sec_ticks counted in RINGING -> IDLE (auto-dismiss).
REQ-025 On snooze, target time = current time + SNOOZE_MINS, minutes mod 60 with carry into hours, hours mod 24 (23:55+9 -> 00:04).
REQ-026 SNOOZE: ring=0; min_tick with time equal target -> RINGING same ring_idx, ring counter cleared; btn_dismiss -> IDLE.
REQ-027 SNOOZE with pending nonzero SHALL abandon the snooze and grant the new slot (pending outranks snooze match).
REQ-028 btn_snooze and btn_dismiss same cycle: dismiss wins.
REQ-029 Writing cfg_en=0 to the ringing/snoozed slot SHALL go to IDLE next edge; writing any slot clears its pending bit.
REQ-030 Dismiss leaves slot enabled; it rings again next day.
REQ-031 Ring counter SHALL clear on every RINGING entry.

Reset
REQ-032 Reset SHALL force IDLE, all slots disabled with time 00:00, pending=0, ring=0, ring_idx=0, snooze_active=0, cfg_err=0, counters and snooze target 0; reset mid-ring drops ring the same instant.

Structure
REQ-033 Package alarm_pkg SHALL hold the state enum, HOURS_PER_DAY=24, MINS_PER_HOUR=60.
REQ-034 Sub-module time_add_mins (combinational hh:mm + n with wrap) SHALL compute the snooze target.

Verification
REQ-035 Slot1=07:30 en; min_tick with 07:30 -> pending[1] at t+1, ring=1 ring_idx=1 at t+2; btn_dismiss -> ring=0 next cycle.
REQ-036 Slots 0 and 2 both 06:00 -> slot 0 rings; dismiss -> slot 2 rings two cycles later.
REQ-037 Ring slot 0 at 23:55, snooze -> snooze_active=1; min_tick 00:04 -> ring=1 ring_idx=0.
REQ-038 RING_SECS=3 ringing, three sec_ticks -> IDLE, ring=0.
REQ-039 Write cfg_hours=24 -> cfg_err pulse, slot unchanged; snooze+dismiss same cycle -> IDLE.
REQ-040 Assert reset while RINGING -> ring=0, pending=0 immediately; no ring after release until a new match.
